dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, memory address width in bits.
REQ-002 SHALL have parameter DW, default 32, data width in bits.
REQ-003 SHALL have parameter MAX_WAIT, default 4, loader aging threshold in cycles; used only with DMEM_ARB_AGING_EN.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset; asynchronous, active-low (0 = reset).
REQ-006 SHALL have port CoreReq  in  1  memory-stage access request; held until granted.
REQ-007 SHALL have ports CoreWe (in, 1), CoreAddr (in, AW), CoreWData (in, DW) carrying the memory-stage write enable, ALU_Result address and write data.
REQ-008 SHALL have port CoreGnt  out  1  core request accepted this cycle.
REQ-009 SHALL have port StallM  out  1  stall the pipeline; equals CoreReq AND NOT CoreGnt.
REQ-010 SHALL have ports CoreRValid (out, 1) and CoreRData (out, DW) carrying the core read-return pulse and data.
REQ-011 SHALL have ports LdReq (in, 1), LdLock (in, 1), LdWe (in, 1), LdAddr (in, AW) and LdWData (in, DW) forming the loader/debug request port.
REQ-012 SHALL have ports LdGnt (out, 1), LdRValid (out, 1) and LdRData (out, DW) carrying the loader grant and read return.
REQ-013 SHALL have ports MemEn (out, 1), MemWe (out, 1), MemAddr (out, AW), MemWData (out, DW) and MemRData (in, DW) forming the synchronous RAM port, with read data valid one cycle after MemEn.

Function
REQ-014 SHALL grant at most one requester per cycle; grants are combinational from current requests and state.
REQ-015 SHALL register the granted command onto Mem* at the end of the grant cycle N; MemEn high only in cycle N+1.
REQ-016 SHALL return read data to the granted owner in cycle N+2, raising CoreRValid or LdRValid for exactly one cycle with the RData mirroring MemRData; writes produce no RValid.
REQ-017 SHALL track in-flight ownership with a 2-stage valid/owner/read shift register, sustaining one grant per cycle back-to-back.
REQ-018 SHALL implement FSM ARB: the core has priority when CoreReq and LdReq are both high; the loader is granted only when CoreReq is low.
REQ-019 SHALL move ARB->LOCK on the cycle the loader is granted with LdLock=1.
REQ-020 SHALL make LOCK grant only the loader, hold CoreGnt=0 (StallM follows CoreReq), and return LOCK->ARB on the first cycle LdLock=0 with no loader grant.
REQ-021 SHALL hold RData outputs at their last value when the matching RValid is 0.
REQ-022 SHALL keep StallM, CoreGnt and LdGnt mutually consistent, never asserting CoreGnt and LdGnt together.

Reset
REQ-023 SHALL, while rst=0, force the FSM to ARB, clear the in-flight pipe, and drive all outputs to 0, including MemAddr, MemWData and RData.
REQ-024 SHALL discard in-flight transactions on reset mid-operation, with no RValid after rst deasserts for commands issued before reset.

Configuration
REQ-025 SHALL, when DMEM_ARB_AGING_EN is defined, count ARB cycles with LdReq=1 and no loader grant, and after MAX_WAIT such cycles grant the loader over the core for one cycle; the counter clears on loader grant or LdReq=0.
REQ-026 SHALL, when DMEM_ARB_AGING_EN is undefined, apply strict core priority in ARB, so the loader may starve, and omit the counter logic.

Verification
REQ-027 SHALL cover: CoreReq=1, CoreWe=1, Addr=0x1, WData=0x32 -> CoreGnt same cycle, MemEn/MemWe=1 with Addr 0x1 in N+1, no CoreRValid.
REQ-028 SHALL cover: core read of Addr 0x1 after that write -> CoreRValid in N+2 with CoreRData=0x32.
REQ-029 SHALL cover: CoreReq and LdReq both high for 6 cycles, no aging macro -> CoreGnt every cycle, LdGnt=0, StallM=0; with the aging macro -> LdGnt in cycle 5 and StallM=1 that cycle.
REQ-030 SHALL cover: LdReq=1, LdLock=1 for 3 writes, then CoreReq=1 -> StallM=1 until the cycle after LdLock drops, then CoreGnt=1.
REQ-031 SHALL cover: rst pulled low one cycle after a read grant -> all outputs 0 and no RValid in the following cycles.
REQ-032 SHALL cover: alternating core/loader reads on consecutive cycles -> each RValid on the correct port exactly 2 cycles after its grant.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous data RAM port between the core memory
// stage and a loader/debug port.
//
// Optional feature macro: DMEM_ARB_AGING_EN. When it is defined, a loader that
// waits MAX_WAIT arbitration cycles wins over the core for one cycle. When it is
// undefined, the core has strict priority and the loader can starve.
//
// Handshake: a requester raises Req with its command and holds both until Gnt is
// high in the same cycle. The command is accepted on that cycle's rising edge.
// Gnt is combinational from the current requests and the arbiter state. A granted
// read returns exactly one RValid pulse two cycles after the grant, and RData is
// valid with that pulse. RData holds its last value when RValid is low.
// arb_state exposes the FSM state for debug (0 = ARB, 1 = LOCK).
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CoreReq,
  input  logic          CoreWe,
  input  logic [AW-1:0] CoreAddr,
  input  logic [DW-1:0] CoreWData,
  output logic          CoreGnt,
  output logic          StallM,
  output logic          CoreRValid,
  output logic [DW-1:0] CoreRData,
  input  logic          LdReq,
  input  logic          LdLock,
  input  logic          LdWe,
  input  logic [AW-1:0] LdAddr,
  input  logic [DW-1:0] LdWData,
  output logic          LdGnt,
  output logic          LdRValid,
  output logic [DW-1:0] LdRData,
  output logic          MemEn,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData,
  output logic          arb_state
);

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic core_gnt;
  logic ld_gnt;
  logic aging_hit;

  // In-flight pipe: stage 1 is the command on Mem*, and MemEn marks it valid.
  // Stage 2 is the cycle in which MemRData carries the read data.
  logic s1_ld;
  logic s1_rd;
  logic s2_valid;
  logic s2_ld;

  logic          core_rv;
  logic          ld_rv;
  logic [DW-1:0] core_rdata_q;
  logic [DW-1:0] ld_rdata_q;

`ifdef DMEM_ARB_AGING_EN
  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;

  // Count the arbitration cycles in which the loader waits. The count saturates
  // at the threshold and clears when the loader is served or drops its request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (ld_gnt || !LdReq) begin
      wait_cnt <= '0;
    end else if ((state == ARB) && (wait_cnt < CW'(MAX_WAIT))) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign aging_hit = (state == ARB) && (wait_cnt >= CW'(MAX_WAIT));
`else
  // Strict core priority: the loader never ages past the core, so MAX_WAIT has no effect.
  assign aging_hit = (MAX_WAIT < 0);
`endif

  // Arbiter state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a locked loader grant enters LOCK. LOCK is released by the
  // first cycle with LdLock low and no loader grant.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (ld_gnt && LdLock) state_nxt = LOCK;
      LOCK:    if (!LdLock && !ld_gnt) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // Grant decode: the core wins in ARB unless the loader has aged. Only the
  // loader is served in LOCK. All grants are forced low while in reset.
  always_comb begin
    core_gnt = 1'b0;
    ld_gnt   = 1'b0;
    if (rst) begin
      if (state == LOCK) begin
        ld_gnt = LdReq;
      end else begin
        core_gnt = CoreReq && !(aging_hit && LdReq);
        ld_gnt   = LdReq && (!CoreReq || aging_hit);
      end
    end
  end

  // Drive the handshake outputs from the grant decode.
  always_comb begin
    CoreGnt   = core_gnt;
    LdGnt     = ld_gnt;
    StallM    = rst && CoreReq && !core_gnt;
    arb_state = state;
  end

  // Register the granted command onto the RAM port and advance the ownership pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MemEn    <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
      s1_ld    <= 1'b0;
      s1_rd    <= 1'b0;
      s2_valid <= 1'b0;
      s2_ld    <= 1'b0;
    end else begin
      MemEn    <= core_gnt || ld_gnt;
      MemWe    <= ld_gnt ? LdWe : (core_gnt && CoreWe);
      s1_ld    <= ld_gnt;
      s1_rd    <= ld_gnt ? !LdWe : (core_gnt && !CoreWe);
      s2_valid <= MemEn && s1_rd;
      s2_ld    <= s1_ld;
      if (ld_gnt) begin
        MemAddr  <= LdAddr;
        MemWData <= LdWData;
      end else if (core_gnt) begin
        MemAddr  <= CoreAddr;
        MemWData <= CoreWData;
      end
    end
  end

  assign core_rv = s2_valid && !s2_ld;
  assign ld_rv   = s2_valid && s2_ld;

  // Keep the last returned word for each owner so RData holds between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_rdata_q <= '0;
      ld_rdata_q   <= '0;
    end else begin
      if (core_rv) core_rdata_q <= MemRData;
      if (ld_rv)   ld_rdata_q   <= MemRData;
    end
  end

  // Return path: pass RAM data straight through on the pulse, otherwise hold it.
  always_comb begin
    CoreRValid = core_rv;
    LdRValid   = ld_rv;
    CoreRData  = core_rv ? MemRData : core_rdata_q;
    LdRData    = ld_rv ? MemRData : ld_rdata_q;
  end

endmodule
